matrix_stream_unpacker: RTL

//  Receiving end of the packed-matrix interface used by the matrix arithmetic units.

---
 rtl/matrix_stream_unpacker_pkg.sv | 24 ++
 rtl/matrix_stream_unpacker_elem_select.sv | 36 +++
 rtl/matrix_stream_unpacker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/matrix_stream_unpacker_pkg.sv
// Shared definitions for the packed-matrix units.
//   DEF_ELEM_W / DEF_N : default element width and matrix dimension
//   state_t            : stream FSM states (IDLE=0, SEND=1)
//   rc_width(n)        : width of a row/column index, max(1, clog2(n))
//   idx_width(n)       : width of a linear element index, max(1, clog2(n*n))
package matrix_stream_unpacker_pkg;

    localparam int DEF_ELEM_W = 4;
    localparam int DEF_N      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int rc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/matrix_stream_unpacker_elem_select.sv
// Combinational element picker for a packed row-major NxN matrix.
//   mat  : packed matrix, element (0,0) in the MSBs
//   row  : row index of the wanted element
//   col  : column index of the wanted element
//   elem : mat[(N*N-1-(row*N+col))*ELEM_W +: ELEM_W]
module matrix_elem_select
    import matrix_stream_unpacker_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int N      = DEF_N,
    localparam int RC_W  = rc_width(N)
) (
    input  logic [N*N*ELEM_W-1:0] mat,
    input  logic [RC_W-1:0]       row,
    input  logic [RC_W-1:0]       col,
    output logic [ELEM_W-1:0]     elem
);

    localparam int NN  = N * N;
    localparam int K_W = idx_width(N);

    // Unpack once with constant slices so the final pick is a plain array index.
    logic [ELEM_W-1:0] elems [NN];
    logic [K_W-1:0]    lin;

    for (genvar g = 0; g < NN; g++) begin : g_unpack
        assign elems[g] = mat[(NN-1-g)*ELEM_W +: ELEM_W];
    end

    // row*N+col never exceeds N*N-1, so K_W bits hold it without overflow.
    always_comb begin
        lin  = K_W'(row) * K_W'(N) + K_W'(col);
        elem = elems[lin];
    end

endmodule

// File: rtl/matrix_stream_unpacker.sv
// Streams the elements of one packed NxN matrix per input handshake, one element per
// output handshake, in row-major or column-major order.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : abort the matrix in flight (back to IDLE next cycle)
//   in_valid      : in_mat / in_col_major valid
//   in_ready      : a matrix can be accepted this cycle
//   in_mat        : packed row-major matrix, element (0,0) in MSBs
//   in_col_major  : 1 selects column-major emission order (captured with in_mat)
//   out_valid     : out_* fields valid
//   out_ready     : consumer takes the current element
//   out_data      : current element
//   out_row/col   : indices of out_data
//   out_last      : out_data is the final element of the matrix
//   mat_count     : matrices fully emitted, wrapping at 16 bits
module matrix_stream_unpacker
    import matrix_stream_unpacker_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int N      = DEF_N,
    localparam int RC_W  = rc_width(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*N*ELEM_W-1:0] in_mat,
    input  logic                  in_col_major,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEM_W-1:0]     out_data,
    output logic [RC_W-1:0]       out_row,
    output logic [RC_W-1:0]       out_col,
    output logic                  out_last,
    output logic [15:0]           mat_count
);

    localparam int             NN     = N * N;
    localparam int             K_W    = idx_width(N);
    localparam logic [K_W-1:0] K_LAST = K_W'(NN - 1);

    state_t                state;
    state_t                state_next;
    logic [NN*ELEM_W-1:0]  mat_q;
    logic                  col_major_q;
    logic [K_W-1:0]        k_q;
    logic [15:0]           count_q;

    logic                  at_last;
    logic                  accept;
    logic                  beat;
    logic                  beat_last;
    logic [K_W-1:0]        k_div;
    logic [K_W-1:0]        k_mod;
    logic [RC_W-1:0]       row;
    logic [RC_W-1:0]       col;
    logic [ELEM_W-1:0]     elem;

    assign at_last   = (k_q == K_LAST);
    assign accept    = in_valid & in_ready;
    assign beat      = out_valid & out_ready;
    assign beat_last = beat & at_last;

    // Linear index -> (row, col); column-major simply swaps the quotient and remainder.
    always_comb begin
        k_div = k_q / K_W'(N);
        k_mod = k_q % K_W'(N);
        if (col_major_q) begin
            row = RC_W'(k_mod);
            col = RC_W'(k_div);
        end else begin
            row = RC_W'(k_div);
            col = RC_W'(k_mod);
        end
    end

    matrix_elem_select #(
        .ELEM_W (ELEM_W),
        .N      (N)
    ) u_elem_select (
        .mat  (mat_q),
        .row  (row),
        .col  (col),
        .elem (elem)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; accept already excludes flush, so flush always lands in IDLE.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = SEND;
                SEND:    if (beat_last && !accept) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs. in_ready sees out_ready combinationally so a new matrix can be taken
    // on the same edge as the previous matrix's last element (no bubble).
    always_comb begin
        out_valid = (state == SEND);
        in_ready  = !rst && !flush &&
                    ((state == IDLE) || (out_valid && at_last && out_ready));
        out_last  = out_valid && at_last;
        out_data  = out_valid ? elem : '0;
        out_row   = out_valid ? row  : '0;
        out_col   = out_valid ? col  : '0;
        mat_count = count_q;
    end

    // Capture register, element counter and completed-matrix counter
    always_ff @(posedge clk) begin
        if (rst) begin
            mat_q       <= '0;
            col_major_q <= 1'b0;
            k_q         <= '0;
            count_q     <= '0;
        end else begin
            if (accept) begin
                mat_q       <= in_mat;
                col_major_q <= in_col_major;
                k_q         <= '0;
            end else if (beat && !at_last) begin
                k_q <= k_q + 1'b1;
            end
            // A last-element handshake coinciding with flush does not count.
            if (beat_last && !flush) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

endmodule
